// File: rtl/commit_sched_pkg.sv
// rtl/commit_sched_pkg.sv - shared constants, head type encodings and FSM states for commit_sched
package commit_sched_pkg;

    // ROB tag width; the regfile uses TAG_NONE (one past the last tag) as "no producer"
    localparam int TAG_W    = 4;
    localparam int TAG_NONE = 16;

    // ROB head instruction classes; the reserved code retires like a plain register write
    localparam logic [1:0] HT_REG    = 2'd0;
    localparam logic [1:0] HT_STORE  = 2'd1;
    localparam logic [1:0] HT_BRANCH = 2'd2;
    localparam logic [1:0] HT_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_ST = 2'd1,
        ST_FLUSH   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/commit_sched.sv
// rtl/commit_sched.sv - in-order retirement scheduler between ROB head and regfile
module commit_sched
    import commit_sched_pkg::*;
#(
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               head_valid,
    input  logic               head_ready,
    input  logic [TAG_W-1:0]   head_tag,
    input  logic [1:0]         head_type,
    input  logic [4:0]         head_rd,
    input  logic [31:0]        head_val,
    input  logic               head_mispred,
    input  logic [31:0]        head_tgt,
    output logic               rob_pop,
    output logic               rob_commit,
    output logic [TAG_W-1:0]   rob_commit_en,
    output logic [31:0]        rob_commit_val,
    output logic [4:0]         rob_commit_addr,
    output logic               st_req,
    output logic [TAG_W-1:0]   st_tag,
    input  logic               st_ack,
    output logic               clear,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        retired
);

    // Counter holds the remaining FLUSH cycles minus one, so it needs FLUSH_CYC-1 at most
    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] flush_cnt;

    logic retire_ok;
    logic is_store;
    logic is_mispred;
    logic st_done;
    logic writes_reg;

    // Retire decision for the current head; stores only dequeue once the LSB acknowledges
    always_comb begin
        retire_ok  = !rst && rdy && (state == ST_IDLE) && head_valid && head_ready;
        is_store   = (head_type == HT_STORE);
        is_mispred = (head_type == HT_BRANCH) && head_mispred;
        writes_reg = retire_ok && !is_store;
        st_done    = !rst && rdy && (state == ST_WAIT_ST) && st_ack;
        rob_pop    = writes_reg || st_done;
    end

    // Retirement FSM plus registered regfile/LSB/flush strobes; rdy=0 freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            flush_cnt       <= '0;
            rob_commit      <= 1'b0;
            rob_commit_en   <= '0;
            rob_commit_val  <= '0;
            rob_commit_addr <= '0;
            st_req          <= 1'b0;
            st_tag          <= '0;
            clear           <= 1'b0;
            redirect_pc     <= '0;
            retired         <= '0;
        end else if (rdy) begin
            rob_commit <= writes_reg;
            clear      <= retire_ok && is_mispred;

            if (writes_reg) begin
                rob_commit_en   <= head_tag;
                rob_commit_addr <= head_rd;
                rob_commit_val  <= head_val;
            end

            if (retire_ok && is_mispred) begin
                redirect_pc <= head_tgt;
            end

            if (rob_pop) begin
                retired <= retired + 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (retire_ok) begin
                        if (is_store) begin
                            state  <= ST_WAIT_ST;
                            st_req <= 1'b1;
                            st_tag <= head_tag;
                        end else if (is_mispred) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT_ST: begin
                    if (st_ack) begin
                        st_req <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
